cdb_arbiter: RTL and testbench

Parametrised completion stage between the functional units and the common data bus. Each of NUM_FU units pushes results into its own skid FIFO. A round-robin arbiter drains up to NUM_CDB results per cycle onto NUM_CDB broadcast ports. This replaces fixed one-bus-per-unit wiring with shared buses, backpressure and flush.

---
 rtl/cdb_arbiter.sv | 171 +++++++++++++++++
 tb/tb_cdb_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-unit completion FIFOs drained round-robin onto shared CDB ports.
// Ports: clk, rst (async, active-low), flush; fu_valid/fu_ready plus packed
//   fu_rob_idx/fu_pd_s/fu_rd_s/fu_rd_v per unit; cdb_valid plus packed
//   cdb_rob_idx/cdb_pd_s/cdb_rd_s/cdb_rd_v/cdb_fu_id per port; conflict_cnt.
module cdb_arbiter #(
    parameter int NUM_FU         = 5,
    parameter int NUM_CDB        = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int ROB_ADDR_WIDTH = 5,
    parameter int PHYS_REG_BITS  = 6,
    parameter int ARCH_REG_BITS  = 5
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic [NUM_FU-1:0]                    fu_valid,
    output logic [NUM_FU-1:0]                    fu_ready,
    input  logic [NUM_FU*ROB_ADDR_WIDTH-1:0]     fu_rob_idx,
    input  logic [NUM_FU*PHYS_REG_BITS-1:0]      fu_pd_s,
    input  logic [NUM_FU*ARCH_REG_BITS-1:0]      fu_rd_s,
    input  logic [NUM_FU*32-1:0]                 fu_rd_v,
    output logic [NUM_CDB-1:0]                   cdb_valid,
    output logic [NUM_CDB*ROB_ADDR_WIDTH-1:0]    cdb_rob_idx,
    output logic [NUM_CDB*PHYS_REG_BITS-1:0]     cdb_pd_s,
    output logic [NUM_CDB*ARCH_REG_BITS-1:0]     cdb_rd_s,
    output logic [NUM_CDB*32-1:0]                cdb_rd_v,
    output logic [NUM_CDB*$clog2(NUM_FU)-1:0]    cdb_fu_id,
    output logic [31:0]                          conflict_cnt
);
    localparam int RW    = ROB_ADDR_WIDTH;
    localparam int PW    = PHYS_REG_BITS;
    localparam int AW    = ARCH_REG_BITS;
    localparam int FID_W = $clog2(NUM_FU);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = RW + PW + AW + 32;

    logic [ENT_W-1:0] r_mem [NUM_FU][FIFO_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr [NUM_FU];
    logic [PTR_W-1:0] r_wr_ptr [NUM_FU];
    logic [CNT_W-1:0] r_count [NUM_FU];
    logic [FID_W-1:0] r_rr_ptr;
    logic [31:0]      r_conflict;

    logic [ENT_W-1:0]  w_in [NUM_FU];
    logic [ENT_W-1:0]  w_head [NUM_FU];
    logic [NUM_FU-1:0] w_nonempty;
    logic [NUM_FU-1:0] w_push;
    logic [NUM_FU-1:0] w_pop;
    logic [FID_W-1:0]  w_next_rr;
    logic              w_conflict;
    int                w_pos [NUM_FU];
    int                w_rank [NUM_FU];
    int                w_ne_cnt;
    int                w_best;

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            w_in[i]       = {fu_rob_idx[i*RW +: RW], fu_pd_s[i*PW +: PW],
                             fu_rd_s[i*AW +: AW], fu_rd_v[i*32 +: 32]};
            w_head[i]     = r_mem[i][r_rd_ptr[i]];
            w_nonempty[i] = (r_count[i] != '0);
            fu_ready[i]   = (r_count[i] != CNT_W'(FIFO_DEPTH));
        end
    end

    // Flush suppresses the write as well; ready itself stays count-based.
    assign w_push = fu_valid & fu_ready & {NUM_FU{~flush}};

    // Each channel's scan position relative to rr_ptr, and its rank among
    // non-empty channels in that order. Rank k drives cdb port k.
    always_comb begin
        w_pop       = '0;
        w_ne_cnt    = 0;
        w_best      = -1;
        w_next_rr   = r_rr_ptr;
        cdb_valid   = '0;
        cdb_rob_idx = '0;
        cdb_pd_s    = '0;
        cdb_rd_s    = '0;
        cdb_rd_v    = '0;
        cdb_fu_id   = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            w_pos[i] = i - int'(r_rr_ptr);
            if (w_pos[i] < 0) begin
                w_pos[i] = w_pos[i] + NUM_FU;
            end
            if (w_nonempty[i]) begin
                w_ne_cnt = w_ne_cnt + 1;
            end
        end
        for (int i = 0; i < NUM_FU; i++) begin
            w_rank[i] = 0;
            for (int j = 0; j < NUM_FU; j++) begin
                if (w_nonempty[j] && (w_pos[j] < w_pos[i])) begin
                    w_rank[i] = w_rank[i] + 1;
                end
            end
            w_pop[i] = !flush && w_nonempty[i] && (w_rank[i] < NUM_CDB);
        end
        // The furthest granted channel in scan order sets the next start.
        for (int i = 0; i < NUM_FU; i++) begin
            if (w_pop[i] && (w_pos[i] > w_best)) begin
                w_best    = w_pos[i];
                w_next_rr = (i == NUM_FU - 1) ? '0 : FID_W'(i + 1);
            end
        end
        for (int p = 0; p < NUM_CDB; p++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (w_pop[i] && (w_rank[i] == p)) begin
                    cdb_valid[p] = 1'b1;
                    {cdb_rob_idx[p*RW +: RW], cdb_pd_s[p*PW +: PW],
                     cdb_rd_s[p*AW +: AW], cdb_rd_v[p*32 +: 32]} = w_head[i];
                    cdb_fu_id[p*FID_W +: FID_W] = FID_W'(i);
                end
            end
        end
    end

    assign w_conflict   = !flush && (w_ne_cnt > NUM_CDB);
    assign conflict_cnt = r_conflict;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wr_ptr[i]] <= w_in[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_FU; i++) begin
                r_count[i]  <= '0;
                r_rd_ptr[i] <= '0;
                r_wr_ptr[i] <= '0;
            end
            r_rr_ptr   <= '0;
            r_conflict <= '0;
        end else if (flush) begin
            for (int i = 0; i < NUM_FU; i++) begin
                r_count[i]  <= '0;
                r_rd_ptr[i] <= '0;
                r_wr_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (w_push[i]) begin
                    r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
                end
                if (w_pop[i]) begin
                    r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
                end
                if (w_push[i] && !w_pop[i]) begin
                    r_count[i] <= r_count[i] + CNT_W'(1);
                end else if (w_pop[i] && !w_push[i]) begin
                    r_count[i] <= r_count[i] - CNT_W'(1);
                end
            end
            r_rr_ptr <= w_next_rr;
            if (w_conflict && (r_conflict != '1)) begin
                r_conflict <= r_conflict + 32'd1;
            end
        end
    end

    // A unit presenting a result while its FIFO is full loses it.
    assert property (@(posedge clk) disable iff (!rst)
        ((fu_valid & ~fu_ready) == '0));

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: table vectors plus hand sequences for cdb_arbiter.
// Per-unit expected queues hold data; tables hold grant order.
module tb_cdb_arbiter;
    localparam int NF = 5;
    localparam int NC = 2;
    localparam int RW = 5;
    localparam int PW = 6;
    localparam int AW = 5;
    localparam int FW = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic [NF-1:0]    fu_valid = '0;
    logic [NF-1:0]    fu_ready;
    logic [NF*RW-1:0] fu_rob_idx = '0;
    logic [NF*PW-1:0] fu_pd_s = '0;
    logic [NF*AW-1:0] fu_rd_s = '0;
    logic [NF*32-1:0] fu_rd_v = '0;
    logic [NC-1:0]    cdb_valid;
    logic [NC*RW-1:0] cdb_rob_idx;
    logic [NC*PW-1:0] cdb_pd_s;
    logic [NC*AW-1:0] cdb_rd_s;
    logic [NC*32-1:0] cdb_rd_v;
    logic [NC*FW-1:0] cdb_fu_id;
    logic [31:0]      conflict_cnt;

    cdb_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_rob_idx(fu_rob_idx), .fu_pd_s(fu_pd_s),
        .fu_rd_s(fu_rd_s), .fu_rd_v(fu_rd_v),
        .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx),
        .cdb_pd_s(cdb_pd_s), .cdb_rd_s(cdb_rd_s),
        .cdb_rd_v(cdb_rd_v), .cdb_fu_id(cdb_fu_id),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [FW-1:0] fu;
        logic [RW-1:0] rob;
        logic [PW-1:0] pd;
        logic [AW-1:0] rd;
        logic [31:0]   v;
    } ent_t;

    typedef struct packed {
        logic [NF-1:0]       mask;
        logic [2:0][1:0]     ev;
        logic [2:0][FW-1:0]  ea;
        logic [2:0][FW-1:0]  eb;
    } vec_t;

    ent_t uq [NF][$];
    vec_t tbl [6];
    int   nchk = 0;
    int   nerr = 0;

    function automatic vec_t mk(logic [NF-1:0] m,
                                logic [1:0] v0, int a0, int b0,
                                logic [1:0] v1, int a1, int b1,
                                logic [1:0] v2, int a2, int b2);
        vec_t r;
        r.mask  = m;
        r.ev[0] = v0; r.ea[0] = FW'(a0); r.eb[0] = FW'(b0);
        r.ev[1] = v1; r.ea[1] = FW'(a1); r.eb[1] = FW'(b1);
        r.ev[2] = v2; r.ea[2] = FW'(a2); r.eb[2] = FW'(b2);
        return r;
    endfunction

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(int u, int rob, int pd, int rd, logic [31:0] v);
        ent_t e;
        fu_valid[u]            = 1'b1;
        fu_rob_idx[u*RW +: RW] = RW'(rob);
        fu_pd_s[u*PW +: PW]    = PW'(pd);
        fu_rd_s[u*AW +: AW]    = AW'(rd);
        fu_rd_v[u*32 +: 32]    = v;
        e = {FW'(u), RW'(rob), PW'(pd), AW'(rd), v};
        uq[u].push_back(e);
    endtask

    function automatic int pending();
        int n = 0;
        for (int u = 0; u < NF; u++) n += uq[u].size();
        return n;
    endfunction

    task automatic clear_sb();
        for (int u = 0; u < NF; u++) uq[u].delete();
    endtask

    task automatic check_out(string nm, bit chkv, logic [1:0] ev,
                             logic [FW-1:0] ea, logic [FW-1:0] eb);
        ent_t got;
        ent_t exp;
        int   u;
        if (chkv) begin
            chk({nm, " valid"}, 64'(cdb_valid), 64'(ev));
            if (ev[0]) chk({nm, " id0"}, 64'(cdb_fu_id[FW-1:0]), 64'(ea));
            if (ev[1]) chk({nm, " id1"}, 64'(cdb_fu_id[2*FW-1:FW]), 64'(eb));
        end
        for (int p = 0; p < NC; p++) begin
            got = {cdb_fu_id[p*FW +: FW], cdb_rob_idx[p*RW +: RW],
                   cdb_pd_s[p*PW +: PW], cdb_rd_s[p*AW +: AW],
                   cdb_rd_v[p*32 +: 32]};
            if (cdb_valid[p]) begin
                u = int'(got.fu);
                if (u >= NF || uq[u].size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL %s port%0d: got broadcast %0h expected none",
                             nm, p, got);
                end else begin
                    exp = uq[u].pop_front();
                    chk($sformatf("%s port%0d data", nm, p), 64'(got), 64'(exp));
                end
            end else begin
                chk($sformatf("%s port%0d idle fields", nm, p), 64'(got), 64'(0));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int   rob1;
        int   rob_o [NF];
        bit   saw_full;
        bit   drained;
        logic [31:0] conf0;

        tbl[0] = mk(5'b11111, 2'b11, 3, 4, 2'b11, 0, 1, 2'b01, 2, 0);
        tbl[1] = mk(5'b00101, 2'b11, 0, 2, 2'b00, 0, 0, 2'b00, 0, 0);
        tbl[2] = mk(5'b00010, 2'b01, 1, 0, 2'b00, 0, 0, 2'b00, 0, 0);
        tbl[3] = mk(5'b11000, 2'b11, 3, 4, 2'b00, 0, 0, 2'b00, 0, 0);
        tbl[4] = mk(5'b10001, 2'b11, 0, 4, 2'b00, 0, 0, 2'b00, 0, 0);
        tbl[5] = mk(5'b01110, 2'b11, 1, 2, 2'b01, 3, 0, 2'b00, 0, 0);

        repeat (2) @(negedge clk);
        chk("reset fu_ready", 64'(fu_ready), 64'h1f);
        chk("reset conflict", 64'(conflict_cnt), 64'd0);
        check_out("reset", 1, 2'b00, 0, 0);
        rst = 1'b1;
        step();
        check_out("idle", 1, 2'b00, 0, 0);

        drive(0, 1, 2, 3, 32'h0000_1111);
        drive(1, 4, 5, 6, 32'h2222_0000);
        drive(3, 8, 9, 10, 32'h3333_4444);
        drive(4, 11, 12, 13, 32'h5555_6666);
        step();
        fu_valid = '0;
        check_out("contend c1", 1, 2'b11, 0, 1);
        step();
        check_out("contend c2", 1, 2'b11, 3, 4);
        step();
        check_out("contend c3", 1, 2'b00, 0, 0);
        chk("contend conflict", 64'(conflict_cnt), 64'd1);

        drive(2, 7, 12, 9, 32'hDEAD_BEEF);
        step();
        fu_valid = '0;
        check_out("single c1", 1, 2'b01, 2, 0);
        step();
        check_out("single c2", 1, 2'b00, 0, 0);

        for (int n = 0; n < 6; n++) begin
            for (int u = 0; u < NF; u++) begin
                if (tbl[n].mask[u]) drive(u, n*5+u, u*7+n+1, u+3*n+1, $urandom);
            end
            step();
            fu_valid = '0;
            for (int c = 0; c < 3; c++) begin
                check_out($sformatf("vec%0d c%0d", n, c+1), 1,
                          tbl[n].ev[c], tbl[n].ea[c], tbl[n].eb[c]);
                if (c < 2) step();
            end
        end
        chk("table conflict", 64'(conflict_cnt), 64'd4);

        step();
        conf0    = conflict_cnt;
        rob1     = 10;
        saw_full = 1'b0;
        for (int u = 0; u < NF; u++) rob_o[u] = 20 + u*4;
        for (int cyc = 0; cyc < 20 && !saw_full; cyc++) begin
            check_out("bp fill", 0, 2'b00, 0, 0);
            fu_valid = '0;
            if (!fu_ready[1]) begin
                saw_full = 1'b1;
            end else begin
                drive(1, rob1, 40, 1, $urandom);
                rob1++;
                for (int u = 0; u < NF; u++) begin
                    if (u != 1 && fu_ready[u]) begin
                        drive(u, rob_o[u], 50+u, u, $urandom);
                        rob_o[u] = (rob_o[u] + 1) % 32;
                    end
                end
                step();
            end
        end
        fu_valid = '0;
        chk("bp ready1 dropped", 64'(saw_full), 64'd1);
        chk("bp unit1 accepted >=4", 64'(rob1 >= 14), 64'd1);
        drained = 1'b0;
        for (int cyc = 0; cyc < 100 && !drained; cyc++) begin
            step();
            check_out("bp drain", 0, 2'b00, 0, 0);
            if (pending() == 0) drained = 1'b1;
        end
        chk("bp drained", 64'(pending()), 64'd0);
        step();
        check_out("bp idle", 1, 2'b00, 0, 0);
        chk("bp ready restored", 64'(fu_ready), 64'h1f);
        chk("bp conflict grew", 64'(conflict_cnt > conf0), 64'd1);

        drive(1, 3, 3, 3, 32'hA1);
        drive(2, 4, 4, 4, 32'hA2);
        drive(3, 5, 5, 5, 32'hA3);
        step();
        fu_valid = '0;
        conf0 = conflict_cnt;
        flush = 1'b1;
        fu_valid[0] = 1'b1;
        fu_rob_idx[RW-1:0] = RW'(31);
        fu_rd_v[31:0] = 32'hBAD0_BAD0;
        #1;
        chk("flush cdb_valid", 64'(cdb_valid), 64'd0);
        chk("flush fu_ready", 64'(fu_ready), 64'h1f);
        clear_sb();
        step();
        flush = 1'b0;
        fu_valid = '0;
        #1;
        chk("post-flush fu_ready", 64'(fu_ready), 64'h1f);
        check_out("post-flush c1", 1, 2'b00, 0, 0);
        step();
        check_out("post-flush c2", 1, 2'b00, 0, 0);
        chk("flush conflict held", 64'(conflict_cnt), 64'(conf0));

        for (int u = 0; u < NF; u++) drive(u, 16+u, u, u, $urandom);
        step();
        fu_valid = '0;
        chk("burst busy", 64'(cdb_valid), 64'h3);
        #2;
        rst = 1'b0;
        #1;
        chk("async rst cdb_valid", 64'(cdb_valid), 64'd0);
        chk("async rst fu_ready", 64'(fu_ready), 64'h1f);
        chk("async rst conflict", 64'(conflict_cnt), 64'd0);
        clear_sb();
        check_out("async rst", 1, 2'b00, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check_out("post-rst idle", 1, 2'b00, 0, 0);
        end
        drive(4, 9, 9, 9, 32'hCAFE_F00D);
        drive(1, 2, 2, 2, 32'h0BAD_CAFE);
        step();
        fu_valid = '0;
        check_out("post-rst rr0", 1, 2'b11, 1, 4);
        step();
        check_out("post-rst end", 1, 2'b00, 0, 0);
        chk("final scoreboard empty", 64'(pending()), 64'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
